// File: rtl/float_to_int_seq_if.sv
// Handshake and data bundle between a float producer/result consumer (master)
// and the float_to_int_seq converter (slave).
interface float_to_int_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        p_lost;
  logic        invalid;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, d, p_lost, invalid
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, d, p_lost, invalid
  );
endinterface

// File: rtl/float_to_int_seq.sv
// Float32 to int32 converter, round toward zero; fixed 7-cycle latency, one op in flight.
// Accepts only in IDLE; the result is held in HOLD until out_ready.
module float_to_int_seq (
  input  logic              clk,
  input  logic              rst_n,
  float_to_int_seq_if.slave io
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_SHIFT, S_PACK, S_HOLD} state_t;
  typedef enum logic [1:0] {C_NORMAL, C_SMALL, C_OVF, C_NAN_INF} cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [31:0] a_q, a_d;
  logic [31:0] w_q, w_d;
  logic [4:0]  sa_q, sa_d;
  logic [2:0]  k_q, k_d;
  logic        sticky_q, sticky_d;
  logic [31:0] d_q, d_d;
  logic        p_lost_q, p_lost_d;
  logic        invalid_q, invalid_d;

  logic [7:0]  exp_v;
  logic [7:0]  sa_full;
  logic [4:0]  shamt;
  logic [31:0] lost_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NORMAL;
      a_q       <= '0;
      w_q       <= '0;
      sa_q      <= '0;
      k_q       <= '0;
      sticky_q  <= 1'b0;
      d_q       <= '0;
      p_lost_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      a_q       <= a_d;
      w_q       <= w_d;
      sa_q      <= sa_d;
      k_q       <= k_d;
      sticky_q  <= sticky_d;
      d_q       <= d_d;
      p_lost_q  <= p_lost_d;
      invalid_q <= invalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    a_d       = a_q;
    w_d       = w_q;
    sa_d      = sa_q;
    k_d       = k_q;
    sticky_d  = sticky_q;
    d_d       = d_q;
    p_lost_d  = p_lost_q;
    invalid_d = invalid_q;
    exp_v     = a_q[30:23];
    sa_full   = 8'd158 - a_q[30:23];
    shamt     = 5'd0;
    lost_mask = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        w_d      = {1'b1, a_q[22:0], 8'b0};
        sa_d     = sa_full[4:0];
        sticky_d = 1'b0;
        k_d      = 3'd4;
        // -2^31 is the only exponent-158 value that fits in int32
        if (exp_v == 8'd255)
          cls_d = C_NAN_INF;
        else if (exp_v > 8'd158 || (exp_v == 8'd158 && a_q != 32'hCF00_0000))
          cls_d = C_OVF;
        else if (exp_v < 8'd127)
          cls_d = C_SMALL;
        else
          cls_d = C_NORMAL;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shamt     = sa_q[k_q] ? (5'd1 << k_q) : 5'd0;
        lost_mask = ~(32'hFFFF_FFFF << shamt);
        w_d       = w_q >> shamt;
        sticky_d  = sticky_q | (|(w_q & lost_mask));
        if (k_q == 3'd0)
          state_d = S_PACK;
        else
          k_d = k_q - 3'd1;
      end
      S_PACK: begin
        case (cls_q)
          C_NORMAL: begin
            d_d       = a_q[31] ? (~w_q + 32'd1) : w_q;
            p_lost_d  = sticky_q;
            invalid_d = 1'b0;
          end
          C_SMALL: begin
            d_d       = 32'd0;
            p_lost_d  = |a_q[30:0];
            invalid_d = 1'b0;
          end
          default: begin
            d_d       = 32'h8000_0000;
            p_lost_d  = 1'b0;
            invalid_d = 1'b1;
          end
        endcase
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (io.out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_HOLD);
  assign io.d         = d_q;
  assign io.p_lost    = p_lost_q;
  assign io.invalid   = invalid_q;

endmodule

// File: tb/tb_float_to_int_seq.sv
// Directed bench for float_to_int_seq: vector table plus backpressure and mid-op reset sequences.
module tb_float_to_int_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  float_to_int_seq_if io ();

  float_to_int_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        p;
    logic        inv;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] val);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a        = val;
    chk("accept_in_ready", 32'(io.in_ready), 32'd1);
    @(negedge clk);
    io.in_valid = 1'b0;
  endtask

  // Called at the falling edge right after the accept edge.
  task automatic wait_result(output int lat);
    logic busy_bad;
    lat      = 0;
    busy_bad = 1'b0;
    while (io.out_valid !== 1'b1 && lat < 30) begin
      if (io.in_ready !== 1'b0) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd7);
    chk("busy_in_ready", 32'(busy_bad), 32'd0);
    chk("hold_in_ready", 32'(io.in_ready), 32'd0);
  endtask

  task automatic check_result(input logic [31:0] ed, input logic ep, input logic einv);
    chk("d", io.d, ed);
    chk("p_lost", 32'(io.p_lost), 32'(ep));
    chk("invalid", 32'(io.invalid), 32'(einv));
  endtask

  task automatic drain();
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("drain_out_valid", 32'(io.out_valid), 32'd0);
    chk("drain_in_ready", 32'(io.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic stale;
    errors = 0;
    checks = 0;

    vecs[0]  = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0};
    vecs[1]  = '{32'hC049_0FDB, 32'hFFFF_FFFD, 1'b1, 1'b0};
    vecs[2]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0};
    vecs[3]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0};
    vecs[4]  = '{32'h4F00_0000, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5]  = '{32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1};
    vecs[6]  = '{32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7]  = '{32'h3F00_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[9]  = '{32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[10] = '{32'h4228_0000, 32'h0000_002A, 1'b0, 1'b0};
    vecs[11] = '{32'hBFC0_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};

    io.in_valid  = 1'b0;
    io.a         = 32'd0;
    io.out_ready = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_d", io.d, 32'd0);
    chk("rst_p_lost", 32'(io.p_lost), 32'd0);
    chk("rst_invalid", 32'(io.invalid), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a);
      wait_result(lat);
      check_result(vecs[i].d, vecs[i].p, vecs[i].inv);
      drain();
    end

    // Backpressure: result must stay frozen while a new operand waits on the input.
    send(32'h4049_0FDB);
    wait_result(lat);
    check_result(32'd3, 1'b1, 1'b0);
    io.in_valid = 1'b1;
    io.a        = 32'h4228_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(io.out_valid), 32'd1);
      chk("bp_in_ready", 32'(io.in_ready), 32'd0);
      check_result(32'd3, 1'b1, 1'b0);
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("bp_release_out_valid", 32'(io.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(io.in_ready), 32'd1);
    @(negedge clk);
    io.in_valid = 1'b0;
    wait_result(lat);
    check_result(32'h0000_002A, 1'b0, 1'b0);
    drain();

    // Reset during SHIFT aborts the conversion with no stale result.
    send(32'h3F80_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
    chk("midrst_d", io.d, 32'd0);
    chk("midrst_in_ready", 32'(io.in_ready), 32'd1);
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (io.out_valid !== 1'b0) stale = 1'b1;
    end
    chk("midrst_no_stale", 32'(stale), 32'd0);
    send(32'hC049_0FDB);
    wait_result(lat);
    check_result(32'hFFFF_FFFD, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
